// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending dispense arbiter: product codes, STATUS
// codes returned with DONE, the controller state encoding and a few helpers
// used by both the top level and the round-robin arbiter.
//
// Contents
//    prod_e      : 2-bit product code (NONE, PEPSI, COKE, DEW)
//    status_e    : 2-bit completion status (OK, SOLD_OUT, INVALID, FAULT)
//    state_e     : controller states (IDLE, CHECK, WAIT_ACK, RUN, FAULT_ST)
//    NUM_PORTS   : number of requester ports
//    NUM_PRODS   : number of real products (NONE excluded)
//    STOCK_MAX   : saturation value of a 4-bit stock counter
//    portOneHot  : 2-bit port index to one-hot port vector
//    oneHotToPort: one-hot port vector to 2-bit port index
//    stockUpdate : one cycle of refill/decrement on a stock counter
// -----------------------------------------------------------------------------
package vend_pkg;

   typedef enum logic [1:0] {
      PROD_NONE  = 2'd0,
      PROD_PEPSI = 2'd1,
      PROD_COKE  = 2'd2,
      PROD_DEW   = 2'd3
   } prod_e;

   typedef enum logic [1:0] {
      STAT_OK       = 2'd0,
      STAT_SOLD_OUT = 2'd1,
      STAT_INVALID  = 2'd2,
      STAT_FAULT    = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHECK    = 3'd1,
      WAIT_ACK = 3'd2,
      RUN      = 3'd3,
      FAULT_ST = 3'd4
   } state_e;

   localparam int         NUM_PORTS = 4;
   localparam int         NUM_PRODS = 3;
   localparam logic [3:0] STOCK_MAX = 4'd15;

   // Turns a port index into the one-hot form used on GNT and DONE.
   function automatic logic [NUM_PORTS-1:0] portOneHot(input logic [1:0] port);
      return 4'b0001 << port;
   endfunction

   // Recovers the port index from a one-hot grant; an all-zero vector maps to
   // port 0, which callers never use because they only look at real grants.
   function automatic logic [1:0] oneHotToPort(input logic [NUM_PORTS-1:0] oneHot);
      logic [1:0] port;
      port = 2'd0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (oneHot[k]) begin
            port = 2'(k);
         end
      end
      return port;
   endfunction

   // Applies a refill and an optional single-unit decrement in the same cycle.
   // The sum is formed first and saturated last, so a refill arriving with a
   // completed vend yields min(15, stock - 1 + add). The decrement is skipped
   // on an empty counter so it can never wrap.
   function automatic logic [3:0] stockUpdate(
      input logic [3:0] cur,
      input logic       dec,
      input logic [3:0] add
   );
      logic [4:0] sum;
      sum = {1'b0, cur} + {1'b0, add};
      if (dec && (sum != 5'd0)) begin
         sum = sum - 5'd1;
      end
      if (sum > {1'b0, STOCK_MAX}) begin
         sum = {1'b0, STOCK_MAX};
      end
      return sum[3:0];
   endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vend_rr_arbiter
// Purely combinational round-robin selector. The search starts at the port
// named by the pointer and wraps around; the first requesting port found is
// granted. The caller owns the pointer and advances it after each grant.
//
// Ports
//    i_req   in  4  request vector, one bit per port
//    i_ptr   in  2  port index where the search begins
//    o_grant out 4  one-hot grant, all zeros when nothing is requesting
// -----------------------------------------------------------------------------
module vend_rr_arbiter
   import vend_pkg::*;
(
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [1:0]           i_ptr,
   output logic [NUM_PORTS-1:0] o_grant
);

   logic       w_found;
   logic [1:0] w_idx;

   // Walk the ports starting at the pointer. The 2-bit index wraps naturally,
   // so ptr=3 searches 3,0,1,2. Only the first hit is granted, which keeps the
   // output one-hot even when every port is requesting.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = i_ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_idx = i_ptr + 2'(k);
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// -----------------------------------------------------------------------------
// vend_dispense_arbiter
// Shares one product dispenser between four requester ports. Requests are
// accepted one at a time in round-robin order, checked against the product
// code and the per-product stock, and then handed to the dispenser. The
// dispenser acknowledges by raising DISP_BUSY and finishes by dropping it.
// A dispenser fault, or no acknowledge within ACK_TIMEOUT cycles, latches
// FAULT and parks the controller until CLR_FAULT.
//
// Parameters
//    ACK_TIMEOUT  cycles to wait in WAIT_ACK for DISP_BUSY before faulting
//    INIT_STOCK   stock loaded into every product counter on reset
//
// Ports
//    CLK          in   1  clock, rising edge
//    RST          in   1  asynchronous active-high reset
//    REQ_VALID    in   4  per-port request, held until that port's GNT
//    REQ_PROD     in   8  2-bit product per port, port i at [2i+1:2i]
//    GNT          out  4  one-hot pulse, request accepted
//    DONE         out  4  one-hot pulse, request completed
//    STATUS       out  2  completion status, valid with DONE
//    DISP_START   out  1  one-cycle dispense command
//    DISP_PROD    out  2  product being dispensed, held until completion
//    DISP_BUSY    in   1  dispenser busy
//    DISP_FAULT   in   1  dispenser fault
//    REFILL_EN    in   1  refill strobe
//    REFILL_PROD  in   2  product to refill (0 ignored)
//    REFILL_CNT   in   4  units to add, saturating at 15
//    CLR_FAULT    in   1  clears the latched fault
//    STOCK        out 12  4-bit stock per product, product p at [4p-1:4p-4]
//    BUSY         out  1  high whenever the controller is not in IDLE
//    FAULT        out  1  latched dispenser fault
// -----------------------------------------------------------------------------
module vend_dispense_arbiter
   import vend_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15,
   parameter int INIT_STOCK  = 8
)(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_PORTS-1:0]   REQ_VALID,
   input  logic [2*NUM_PORTS-1:0] REQ_PROD,
   output logic [NUM_PORTS-1:0]   GNT,
   output logic [NUM_PORTS-1:0]   DONE,
   output logic [1:0]             STATUS,
   output logic                   DISP_START,
   output logic [1:0]             DISP_PROD,
   input  logic                   DISP_BUSY,
   input  logic                   DISP_FAULT,
   input  logic                   REFILL_EN,
   input  logic [1:0]             REFILL_PROD,
   input  logic [3:0]             REFILL_CNT,
   input  logic                   CLR_FAULT,
   output logic [4*NUM_PRODS-1:0] STOCK,
   output logic                   BUSY,
   output logic                   FAULT
);

   localparam int                 CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_e                 r_state;
   state_e                 w_stateNext;
   logic [1:0]             r_ptr;
   logic [1:0]             w_ptrNext;
   logic [1:0]             r_port;
   logic [1:0]             w_portNext;
   logic [1:0]             r_prod;
   logic [1:0]             w_prodNext;
   logic [CNT_W-1:0]       r_ackCnt;
   logic [CNT_W-1:0]       w_ackCntNext;
   logic [NUM_PORTS-1:0]   r_gnt;
   logic [NUM_PORTS-1:0]   w_gntNext;
   logic [NUM_PORTS-1:0]   r_done;
   logic [NUM_PORTS-1:0]   w_doneNext;
   logic [1:0]             r_status;
   logic [1:0]             w_statusNext;
   logic                   r_dispStart;
   logic                   w_dispStartNext;
   logic [1:0]             r_dispProd;
   logic [1:0]             w_dispProdNext;
   logic                   r_fault;
   logic                   w_faultNext;
   logic                   w_decEn;
   logic [3:0]             w_curStock;
   logic [3:0]             r_stock     [NUM_PRODS];
   logic [3:0]             w_stockNext [NUM_PRODS];
   logic [NUM_PORTS-1:0]   w_arbGrant;
   logic [1:0]             w_arbPort;

   vend_rr_arbiter u_rrArbiter (
      .i_req   (REQ_VALID),
      .i_ptr   (r_ptr),
      .o_grant (w_arbGrant)
   );

   assign w_arbPort = oneHotToPort(w_arbGrant);

   // Stock of the product latched for the current request. NONE has no
   // counter, so it reads as zero; CHECK tests for NONE before using this.
   always_comb begin
      w_curStock = 4'd0;
      case (r_prod)
         PROD_PEPSI: w_curStock = r_stock[0];
         PROD_COKE:  w_curStock = r_stock[1];
         PROD_DEW:   w_curStock = r_stock[2];
         default:    w_curStock = 4'd0;
      endcase
   end

   // Controller next-state and registered-output logic. Every output is
   // computed here and captured by the state register, so GNT appears the
   // cycle after a request is seen in IDLE and DONE at least one cycle later.
   // Any path that ends a transaction (reject, completion or fault) produces
   // exactly one DONE pulse for the latched port, and new grants are only
   // issued from IDLE, so a port can never be re-granted before its DONE.
   always_comb begin
      w_stateNext     = r_state;
      w_ptrNext       = r_ptr;
      w_portNext      = r_port;
      w_prodNext      = r_prod;
      w_ackCntNext    = r_ackCnt;
      w_gntNext       = '0;
      w_doneNext      = '0;
      w_statusNext    = STAT_OK;
      w_dispStartNext = 1'b0;
      w_dispProdNext  = r_dispProd;
      w_faultNext     = r_fault;
      w_decEn         = 1'b0;

      case (r_state)
         IDLE: begin
            if (|REQ_VALID) begin
               w_gntNext   = w_arbGrant;
               w_portNext  = w_arbPort;
               w_prodNext  = REQ_PROD[{w_arbPort, 1'b0} +: 2];
               w_ptrNext   = w_arbPort + 2'd1;
               w_stateNext = CHECK;
            end
         end

         CHECK: begin
            if (r_prod == PROD_NONE) begin
               w_doneNext   = portOneHot(r_port);
               w_statusNext = STAT_INVALID;
               w_stateNext  = IDLE;
            end else if (w_curStock == 4'd0) begin
               w_doneNext   = portOneHot(r_port);
               w_statusNext = STAT_SOLD_OUT;
               w_stateNext  = IDLE;
            end else begin
               w_dispStartNext = 1'b1;
               w_dispProdNext  = r_prod;
               w_ackCntNext    = '0;
               w_stateNext     = WAIT_ACK;
            end
         end

         WAIT_ACK: begin
            if (DISP_FAULT || (!DISP_BUSY && (r_ackCnt == CNT_LAST))) begin
               w_doneNext     = portOneHot(r_port);
               w_statusNext   = STAT_FAULT;
               w_faultNext    = 1'b1;
               w_dispProdNext = 2'd0;
               w_stateNext    = FAULT_ST;
            end else if (DISP_BUSY) begin
               w_stateNext = RUN;
            end else begin
               w_ackCntNext = r_ackCnt + 1'b1;
            end
         end

         RUN: begin
            if (DISP_FAULT) begin
               w_doneNext     = portOneHot(r_port);
               w_statusNext   = STAT_FAULT;
               w_faultNext    = 1'b1;
               w_dispProdNext = 2'd0;
               w_stateNext    = FAULT_ST;
            end else if (!DISP_BUSY) begin
               w_doneNext     = portOneHot(r_port);
               w_statusNext   = STAT_OK;
               w_decEn        = 1'b1;
               w_dispProdNext = 2'd0;
               w_stateNext    = IDLE;
            end
         end

         FAULT_ST: begin
            if (CLR_FAULT) begin
               w_faultNext = 1'b0;
               w_stateNext = IDLE;
            end
         end

         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // State register and registered outputs. Reset is asynchronous so a reset
   // in the middle of a vend drops every output at once and abandons the
   // transaction without a DONE pulse.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_ptr       <= 2'd0;
         r_port      <= 2'd0;
         r_prod      <= 2'd0;
         r_ackCnt    <= '0;
         r_gnt       <= '0;
         r_done      <= '0;
         r_status    <= 2'd0;
         r_dispStart <= 1'b0;
         r_dispProd  <= 2'd0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_ptr       <= w_ptrNext;
         r_port      <= w_portNext;
         r_prod      <= w_prodNext;
         r_ackCnt    <= w_ackCntNext;
         r_gnt       <= w_gntNext;
         r_done      <= w_doneNext;
         r_status    <= w_statusNext;
         r_dispStart <= w_dispStartNext;
         r_dispProd  <= w_dispProdNext;
         r_fault     <= w_faultNext;
      end
   end

   // Per-product stock next values. A refill and a completed vend of the same
   // product can land in the same cycle; both are folded into one update so
   // neither is lost. REFILL_PROD of NONE matches no counter and is ignored.
   always_comb begin
      for (int p = 0; p < NUM_PRODS; p++) begin
         w_stockNext[p] = stockUpdate(
            r_stock[p],
            w_decEn && (r_prod == 2'(p + 1)),
            (REFILL_EN && (REFILL_PROD == 2'(p + 1))) ? REFILL_CNT : 4'd0
         );
      end
   end

   // Stock counters, reloaded with INIT_STOCK on every reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int p = 0; p < NUM_PRODS; p++) begin
            r_stock[p] <= 4'(INIT_STOCK);
         end
      end else begin
         for (int p = 0; p < NUM_PRODS; p++) begin
            r_stock[p] <= w_stockNext[p];
         end
      end
   end

   assign GNT        = r_gnt;
   assign DONE       = r_done;
   assign STATUS     = r_status;
   assign DISP_START = r_dispStart;
   assign DISP_PROD  = r_dispProd;
   assign FAULT      = r_fault;
   assign BUSY       = (r_state != IDLE);
   assign STOCK      = {r_stock[2], r_stock[1], r_stock[0]};

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
module tb_vend_dispense_arbiter;

   localparam int ACK_TIMEOUT = 15;
   localparam int INIT_STOCK  = 8;
   localparam int DONE_LIMIT  = 4;

   logic        CLK;
   logic        RST;
   logic [3:0]  REQ_VALID;
   logic [7:0]  REQ_PROD;
   logic [3:0]  GNT;
   logic [3:0]  DONE;
   logic [1:0]  STATUS;
   logic        DISP_START;
   logic [1:0]  DISP_PROD;
   logic        DISP_BUSY;
   logic        DISP_FAULT;
   logic        REFILL_EN;
   logic [1:0]  REFILL_PROD;
   logic [3:0]  REFILL_CNT;
   logic        CLR_FAULT;
   logic [11:0] STOCK;
   logic        BUSY;
   logic        FAULT;

   int checks;
   int failures;
   int rrPtr;
   int stockModel [4];

   vend_dispense_arbiter #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .INIT_STOCK  (INIT_STOCK)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .REQ_VALID   (REQ_VALID),
      .REQ_PROD    (REQ_PROD),
      .GNT         (GNT),
      .DONE        (DONE),
      .STATUS      (STATUS),
      .DISP_START  (DISP_START),
      .DISP_PROD   (DISP_PROD),
      .DISP_BUSY   (DISP_BUSY),
      .DISP_FAULT  (DISP_FAULT),
      .REFILL_EN   (REFILL_EN),
      .REFILL_PROD (REFILL_PROD),
      .REFILL_CNT  (REFILL_CNT),
      .CLR_FAULT   (CLR_FAULT),
      .STOCK       (STOCK),
      .BUSY        (BUSY),
      .FAULT       (FAULT)
   );

   // Free-running 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance one clock and settle just after the edge, where outputs are read
   // and the next inputs are driven.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference model helpers: saturating add, packed stock image, reset state.
   function automatic int sat15(input int value);
      return (value > 15) ? 15 : value;
   endfunction

   function automatic logic [11:0] packStock();
      return {4'(stockModel[3]), 4'(stockModel[2]), 4'(stockModel[1])};
   endfunction

   task automatic resetModel();
      rrPtr = 0;
      for (int p = 1; p <= 3; p++) stockModel[p] = INIT_STOCK;
   endtask

   // Round-robin choice: the first pending port at or after the pointer.
   function automatic int pickPort(input logic [3:0] pending, input int ptr);
      int chosen;
      chosen = -1;
      for (int k = 0; k < 4; k++) begin
         if (chosen < 0 && pending[(ptr + k) % 4]) chosen = (ptr + k) % 4;
      end
      return chosen;
   endfunction

   // Raise requests on ports in the mask that are not already waiting; a
   // waiting requester keeps its original product.
   task automatic applyStimulus(input logic [3:0] mask, input logic [7:0] prods);
      for (int i = 0; i < 4; i++) begin
         if (mask[i] && !REQ_VALID[i]) begin
            REQ_VALID[i]        = 1'b1;
            REQ_PROD[2*i +: 2]  = prods[2*i +: 2];
         end
      end
   endtask

   // One refill strobe in IDLE, checked against the model.
   task automatic applyRefill(input int prod, input int cnt);
      REFILL_EN   = 1'b1;
      REFILL_PROD = 2'(prod);
      REFILL_CNT  = 4'(cnt);
      tick();
      REFILL_EN   = 1'b0;
      REFILL_PROD = 2'd0;
      REFILL_CNT  = 4'd0;
      if (prod != 0) stockModel[prod] = sat15(stockModel[prod] + cnt);
      checkOutput("refill_stock", STOCK, packStock());
   endtask

   // Serve the next request the model expects to be granted.
   // mode 0: dispenser busy for busyCycles, then completes (optional refill on
   //         the completion cycle); mode 1: dispenser never acknowledges;
   // mode 2: dispenser faults after busyCycles of RUN.
   task automatic serveNext(input int busyCycles, input int mode, input int refillProd,
                            input int refillCnt, output bit faulted);
      int   port;
      int   prod;
      int   waitCnt;
      logic stray;
      faulted = 1'b0;
      port = pickPort(REQ_VALID, rrPtr);
      if (port < 0) begin
         $display("[TB] serveNext called with no pending request");
         return;
      end
      prod = int'(REQ_PROD[2*port +: 2]);
      tick();
      checkOutput("gnt", 32'(GNT), 32'(1) << port);
      checkOutput("busy_after_gnt", 32'(BUSY), 1);
      REQ_VALID[port] = 1'b0;
      rrPtr = (port + 1) % 4;
      tick();
      if (prod == 0 || stockModel[prod] == 0) begin
         checkOutput("done_reject", 32'(DONE), 32'(1) << port);
         checkOutput("status_reject", 32'(STATUS), (prod == 0) ? 2 : 1);
         checkOutput("no_disp_start", 32'(DISP_START), 0);
         checkOutput("stock_reject", 32'(STOCK), 32'(packStock()));
         return;
      end
      checkOutput("disp_start", 32'(DISP_START), 1);
      checkOutput("disp_prod", 32'(DISP_PROD), prod);
      checkOutput("done_not_yet", 32'(DONE), 0);
      if (mode != 1) begin
         stray = 1'b0;
         DISP_BUSY = 1'b1;
         for (int c = 0; c < busyCycles; c++) begin
            tick();
            if (GNT !== 4'b0 || DONE !== 4'b0 || DISP_START !== 1'b0 || DISP_PROD !== 2'(prod)) stray = 1'b1;
         end
         checkOutput("quiet_while_busy", 32'(stray), 0);
      end
      if (mode == 0) begin
         DISP_BUSY = 1'b0;
         if (refillCnt > 0) begin
            REFILL_EN   = 1'b1;
            REFILL_PROD = 2'(refillProd);
            REFILL_CNT  = 4'(refillCnt);
         end
         tick();
         REFILL_EN   = 1'b0;
         REFILL_PROD = 2'd0;
         REFILL_CNT  = 4'd0;
         waitCnt = 0;
         while (DONE === 4'b0 && waitCnt < DONE_LIMIT) begin
            tick();
            waitCnt++;
         end
         stockModel[prod] = stockModel[prod] - 1;
         if (refillCnt > 0 && refillProd != 0) stockModel[refillProd] = sat15(stockModel[refillProd] + refillCnt);
         checkOutput("done_ok", 32'(DONE), 32'(1) << port);
         checkOutput("status_ok", 32'(STATUS), 0);
         checkOutput("stock_after_vend", 32'(STOCK), 32'(packStock()));
      end else begin
         if (mode == 2) begin
            DISP_FAULT = 1'b1;
            tick();
            DISP_FAULT = 1'b0;
            DISP_BUSY  = 1'b0;
            waitCnt = 0;
            while (DONE === 4'b0 && waitCnt < DONE_LIMIT) begin
               tick();
               waitCnt++;
            end
         end else begin
            waitCnt = 0;
            while (DONE === 4'b0 && waitCnt < ACK_TIMEOUT + 5) begin
               tick();
               waitCnt++;
            end
            checkOutput("timeout_cycles", 32'(waitCnt), ACK_TIMEOUT);
         end
         faulted = 1'b1;
         checkOutput("done_fault", 32'(DONE), 32'(1) << port);
         checkOutput("status_fault", 32'(STATUS), 3);
         checkOutput("fault_flag", 32'(FAULT), 1);
         checkOutput("stock_after_fault", 32'(STOCK), 32'(packStock()));
      end
   endtask

   // Hold in the fault state for a while (no grants allowed even with
   // requests pending), then clear it and expect a return to IDLE.
   task automatic clearFault(input int holdCycles);
      logic stray;
      stray = 1'b0;
      for (int c = 0; c < holdCycles; c++) begin
         tick();
         if (GNT !== 4'b0 || DONE !== 4'b0 || FAULT !== 1'b1 || BUSY !== 1'b1) stray = 1'b1;
      end
      checkOutput("fault_hold", 32'(stray), 0);
      CLR_FAULT = 1'b1;
      tick();
      CLR_FAULT = 1'b0;
      checkOutput("fault_cleared", 32'(FAULT), 0);
      checkOutput("idle_after_clear", 32'(BUSY), 0);
      checkOutput("no_gnt_on_clear", 32'(GNT), 0);
   endtask

   // Directed scenarios followed by a randomized run, then a reset mid-vend.
   initial begin
      bit         faulted;
      logic [3:0] mask;
      logic [7:0] prodVec;
      int         mode;
      logic       stray;

      checks      = 0;
      failures    = 0;
      RST         = 1'b1;
      REQ_VALID   = 4'b0;
      REQ_PROD    = 8'b0;
      DISP_BUSY   = 1'b0;
      DISP_FAULT  = 1'b0;
      REFILL_EN   = 1'b0;
      REFILL_PROD = 2'd0;
      REFILL_CNT  = 4'd0;
      CLR_FAULT   = 1'b0;
      resetModel();
      tick();
      tick();
      checkOutput("rst_outputs", 32'({GNT, DONE, STATUS, DISP_START, DISP_PROD, BUSY, FAULT}), 0);
      checkOutput("rst_stock", 32'(STOCK), 32'h888);
      RST = 1'b0;
      tick();
      checkOutput("idle_after_rst", 32'(BUSY), 0);

      $display("[TB] port1 COKE vend with 5 busy cycles");
      applyStimulus(4'b0010, 8'b00_00_10_00);
      serveNext(5, 0, 0, 0, faulted);
      checkOutput("coke_stock_7", 32'(STOCK[7:4]), 7);

      $display("[TB] port3 PEPSI to wrap the pointer, then all four ports at once");
      applyStimulus(4'b1000, 8'b01_00_00_00);
      serveNext(2, 0, 0, 0, faulted);
      for (int i = 0; i < 4; i++) prodVec[2*i +: 2] = 2'($urandom_range(1, 3));
      applyStimulus(4'b1111, prodVec);
      for (int i = 0; i < 4; i++) serveNext($urandom_range(1, 4), 0, 0, 0, faulted);

      $display("[TB] drain DEW, then SOLD_OUT and INVALID requests");
      for (int i = 0; i < 20; i++) begin
         if (stockModel[3] > 0) begin
            applyStimulus(4'b0001, 8'b00_00_00_11);
            serveNext(1, 0, 0, 0, faulted);
         end
      end
      checkOutput("dew_empty", 32'(STOCK[11:8]), 0);
      applyStimulus(4'b0100, 8'b00_11_00_00);
      serveNext(3, 0, 0, 0, faulted);
      applyStimulus(4'b1000, 8'b00_00_00_00);
      serveNext(3, 0, 0, 0, faulted);

      $display("[TB] refills and saturation");
      applyRefill(0, 5);
      applyRefill(3, 4);
      applyRefill(1, 14 - stockModel[1]);
      checkOutput("pepsi_14", 32'(STOCK[3:0]), 14);
      applyStimulus(4'b0001, 8'b00_00_00_01);
      serveNext(2, 0, 1, 5, faulted);
      checkOutput("pepsi_sat", 32'(STOCK[3:0]), 15);
      applyRefill(2, 15);
      checkOutput("coke_sat", 32'(STOCK[7:4]), 15);

      $display("[TB] acknowledge timeout and fault during RUN");
      applyStimulus(4'b0010, 8'b00_00_10_00);
      serveNext(0, 1, 0, 0, faulted);
      applyStimulus(4'b0100, 8'b00_10_00_00);
      clearFault(4);
      serveNext(2, 0, 0, 0, faulted);
      applyStimulus(4'b0001, 8'b00_00_00_01);
      serveNext(3, 2, 0, 0, faulted);
      clearFault(2);

      $display("[TB] randomized traffic");
      for (int it = 0; it < 24; it++) begin
         if (REQ_VALID == 4'b0 && $urandom_range(0, 3) == 0) applyRefill($urandom_range(0, 3), $urandom_range(0, 15));
         mask    = 4'($urandom_range(1, 15));
         prodVec = 8'($urandom);
         applyStimulus(mask, prodVec);
         mode = ($urandom_range(0, 7) == 0) ? 2 : 0;
         serveNext($urandom_range(1, 6), mode, 0, 0, faulted);
         if (faulted) clearFault(2);
      end
      for (int i = 0; i < 4; i++) begin
         if (REQ_VALID != 4'b0) begin
            serveNext(1, 0, 0, 0, faulted);
         end
      end

      $display("[TB] reset in the middle of RUN");
      applyStimulus(4'b0010, 8'b00_00_10_00);
      tick();
      checkOutput("gnt_before_rst", 32'(GNT), 32'b0010);
      REQ_VALID[1] = 1'b0;
      tick();
      DISP_BUSY = 1'b1;
      tick();
      tick();
      RST = 1'b1;
      #1;
      checkOutput("rst_mid_outputs", 32'({GNT, DONE, STATUS, DISP_START, DISP_PROD, BUSY, FAULT}), 0);
      checkOutput("rst_mid_stock", 32'(STOCK), 32'h888);
      DISP_BUSY = 1'b0;
      stray = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (DONE !== 4'b0) stray = 1'b1;
      end
      RST = 1'b0;
      resetModel();
      tick();
      if (DONE !== 4'b0) stray = 1'b1;
      checkOutput("no_done_after_rst", 32'(stray), 0);
      applyStimulus(4'b1001, 8'b10_00_00_01);
      serveNext(2, 0, 0, 0, faulted);
      serveNext(2, 0, 0, 0, faulted);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vend_dispense_arbiter.md
VEND_DISPENSE_ARBITER -- requirements
Module: vend_dispense_arbiter

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15: maximum cycles to wait for DISP_BUSY after DISP_START.
REQ-002 SHALL have parameter INIT_STOCK, default 8: stock count loaded for each product on reset.
REQ-003 SHALL have ports in this order:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  4  per-port vend request; held by the requester until its GNT bit pulses.
- REQ_PROD  in  8  2-bit product code per port, port i at [2i+1:2i]; 0=NONE, 1=PEPSI, 2=COKE, 3=DEW.
- GNT  out  4  one-hot, one-cycle pulse: request accepted.
- DONE  out  4  one-hot, one-cycle pulse: request completed.
- STATUS  out  2  valid with DONE; 0=OK, 1=SOLD_OUT, 2=INVALID, 3=FAULT.
- DISP_START  out  1  one-cycle dispense command to the shared dispenser.
- DISP_PROD  out  2  product to dispense; held stable from DISP_START until completion.
- DISP_BUSY  in  1  dispenser busy.
- DISP_FAULT  in  1  dispenser fault.
- REFILL_EN  in  1  refill strobe.
- REFILL_PROD  in  2  product to refill.
- REFILL_CNT  in  4  units to add.
- CLR_FAULT  in  1  clears the latched fault.
- STOCK  out  12  4-bit stock per product, product p at [4p-1:4p-4].
- BUSY  out  1  high whenever the FSM is not in IDLE.
- FAULT  out  1  latched dispenser fault.

Function
REQ-004 SHALL use FSM states IDLE, CHECK, WAIT_ACK, RUN, FAULT_ST.
REQ-005 IDLE: when any REQ_VALID is high, SHALL grant one port round-robin, starting search at the pointer; SHALL pulse GNT[i]; SHALL latch port and product; next state CHECK.
REQ-006 SHALL set the round-robin pointer to (granted+1) mod 4 on each grant; pointer resets to 0.
REQ-007 CHECK, product NONE: SHALL pulse DONE[i] with STATUS=INVALID and return to IDLE.
REQ-008 CHECK, product stock 0: SHALL pulse DONE[i] with STATUS=SOLD_OUT and return to IDLE.
REQ-009 CHECK, otherwise: SHALL pulse DISP_START, drive DISP_PROD, and go to WAIT_ACK.
REQ-010 WAIT_ACK: DISP_BUSY=1 SHALL move to RUN; after ACK_TIMEOUT cycles with no busy, SHALL enter FAULT_ST.
REQ-011 RUN: on DISP_BUSY falling to 0, SHALL decrement the product's stock, pulse DONE[i] with STATUS=OK, and return to IDLE.
REQ-012 DISP_FAULT=1 in WAIT_ACK or RUN SHALL enter FAULT_ST, pulse DONE[i] with STATUS=FAULT, set FAULT=1, and leave stock unchanged. A timeout SHALL produce the same response.
REQ-013 FAULT_ST SHALL hold until CLR_FAULT=1, then clear FAULT and go to IDLE; no grants while in FAULT_ST.
REQ-014 Minimum request latency SHALL be: GNT in the cycle after REQ_VALID is sampled in IDLE, then DONE no earlier than 1 cycle after GNT.
REQ-015 REFILL_EN SHALL add REFILL_CNT to the product stock, saturating at 15; REFILL_PROD=0 SHALL be ignored.
REQ-016 Refill and decrement of the same product in the same cycle SHALL give min(15, stock-1+REFILL_CNT).
REQ-017 At most one DONE bit and one GNT bit SHALL be high per cycle; a port's request SHALL not be re-granted before its DONE.
REQ-018 REQ_VALID dropping after GNT SHALL not abort the vend.

Reset
REQ-019 RST SHALL asynchronously force state IDLE and pointer 0.
REQ-020 RST SHALL force GNT, DONE, STATUS, DISP_START, DISP_PROD, BUSY and FAULT to 0.
REQ-021 RST SHALL load every stock count with INIT_STOCK.
REQ-022 RST mid-vend SHALL abandon the transaction without any DONE pulse.

Structure
REQ-023 Package vend_pkg SHALL hold the product codes, STATUS codes and FSM state enum.
REQ-024 Round-robin selection SHALL be a sub-module vend_rr_arbiter (4 requests in, pointer in, one-hot grant out).

Verification
REQ-025 Port1 requests COKE, stock 8, dispenser busy for 5 cycles -> GNT=0010, DISP_START with DISP_PROD=2, DONE=0010 with STATUS=OK, COKE stock 7.
REQ-026 All 4 ports request together, pointer 0 -> grant order 0,1,2,3, each DONE before the next GNT.
REQ-027 Port2 requests DEW with stock 0 -> DONE=0100 with STATUS=SOLD_OUT, no DISP_START; port3 requests NONE -> STATUS=INVALID.
REQ-028 DISP_BUSY never rises -> FAULT_ST after 15 cycles, STATUS=FAULT, FAULT=1, no grants until CLR_FAULT.
REQ-029 PEPSI stock 14, refill of 5 in the same cycle as a PEPSI completion -> stock 15 (saturated).
REQ-030 RST asserted during RUN -> all outputs 0 immediately, no DONE, stocks reset to 8.
